// File: rtl/store_rmw_unit_pkg.sv
// Shared types and constants for the store read-modify-write unit.
// Holds the store-size encoding, FSM state enum and alignment rule.
package store_rmw_unit_pkg;

  localparam int DW_BYTES = 8;

  typedef enum logic [1:0] {
    SZ_D = 2'b00,
    SZ_W = 2'b01,
    SZ_H = 2'b10,
    SZ_B = 2'b11
  } store_size_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // A store is aligned when its byte offset is a multiple of its size.
  function automatic logic is_misaligned(input store_size_t size, input logic [2:0] off);
    case (size)
      SZ_D:    return off != 3'b000;
      SZ_W:    return off[1:0] != 2'b00;
      SZ_H:    return off[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_rmw_unit_if.sv
// Request and data-memory signals of the store read-modify-write unit.
// master drives requests and memory read data; slave is the unit itself.
interface store_rmw_unit_if;
  logic        DMemWrite;
  logic [1:0]  tam;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] mem_rdata;
  logic [63:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [63:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        misalign;

  modport master (
    output DMemWrite, tam, addr, wdata, mem_rdata,
    input  mem_addr, mem_rd, mem_wr, mem_wdata, busy, done, misalign
  );

  modport slave (
    input  DMemWrite, tam, addr, wdata, mem_rdata,
    output mem_addr, mem_rd, mem_wr, mem_wdata, busy, done, misalign
  );
endinterface

// File: rtl/store_rmw_unit_merge.sv
// Little-endian lane merge: overwrites only the bytes addressed by a
// sub-doubleword store and keeps every other byte of the old doubleword.
module store_byte_merge
  import store_rmw_unit_pkg::*;
(
  input  logic [DW_BYTES*8-1:0] old,
  input  logic [DW_BYTES*8-1:0] data,
  input  store_size_t           size,
  input  logic [2:0]            offset,
  output logic [DW_BYTES*8-1:0] merged
);

  localparam int DW = DW_BYTES * 8;

  logic [DW-1:0] w_lane_mask;
  logic [DW-1:0] w_mask;
  logic [DW-1:0] w_shifted;
  logic [2:0]    w_lane;

  always_comb begin
    w_lane      = 3'd0;
    w_lane_mask = '1;
    case (size)
      SZ_W: begin
        w_lane      = {offset[2], 2'b00};
        w_lane_mask = 64'h0000_0000_FFFF_FFFF;
      end
      SZ_H: begin
        w_lane      = {offset[2:1], 1'b0};
        w_lane_mask = 64'h0000_0000_0000_FFFF;
      end
      SZ_B: begin
        w_lane      = offset;
        w_lane_mask = 64'h0000_0000_0000_00FF;
      end
      default: ;
    endcase
    w_mask    = w_lane_mask << {w_lane, 3'b000};
    w_shifted = (data & w_lane_mask) << {w_lane, 3'b000};
    merged    = (old & ~w_mask) | (w_shifted & w_mask);
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store unit: doubleword stores write directly; narrower stores read the
// containing doubleword, merge the new lanes and write it back.
module store_rmw_unit
  import store_rmw_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  store_rmw_unit_if.slave   bus
);

  state_t      r_state;
  state_t      w_next;
  logic [63:0] r_addr_q;
  logic [63:0] r_wdata_q;
  logic [63:0] r_old_q;
  store_size_t r_tam_q;
  logic [63:0] w_merged;
  logic        w_accept;
  logic        w_mem_rd;
  logic        w_mem_wr;
  logic        w_busy;
  logic        w_misalign;

  assign w_accept = (r_state == ST_IDLE) && bus.DMemWrite;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = ST_IDLE;
    w_mem_rd   = 1'b0;
    w_mem_wr   = 1'b0;
    w_busy     = 1'b0;
    w_misalign = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.DMemWrite) begin
          if (is_misaligned(store_size_t'(bus.tam), bus.addr[2:0])) w_next = ST_ERR;
          else if (store_size_t'(bus.tam) == SZ_D)                 w_next = ST_WRITE;
          else                                                      w_next = ST_READ;
        end
      end
      ST_READ: begin
        w_mem_rd = 1'b1;
        w_busy   = 1'b1;
        w_next   = ST_WAIT;
      end
      ST_WAIT: begin
        w_busy = 1'b1;
        w_next = ST_WRITE;
      end
      ST_WRITE: begin
        w_mem_wr = 1'b1;
        w_busy   = 1'b1;
      end
      ST_ERR: begin
        w_misalign = 1'b1;
        w_busy     = 1'b1;
      end
      default: ;
    endcase
  end

  // Request capture happens only in IDLE; old_q samples the read return in WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr_q  <= '0;
      r_wdata_q <= '0;
      r_tam_q   <= SZ_D;
      r_old_q   <= '0;
    end else begin
      if (w_accept) begin
        r_addr_q  <= bus.addr;
        r_wdata_q <= bus.wdata;
        r_tam_q   <= store_size_t'(bus.tam);
      end
      if (r_state == ST_WAIT) r_old_q <= bus.mem_rdata;
    end
  end

  // Doubleword stores pass straight through the merge.
  store_byte_merge u_merge (
    .old    (r_old_q),
    .data   (r_wdata_q),
    .size   (r_tam_q),
    .offset (r_addr_q[2:0]),
    .merged (w_merged)
  );

  assign bus.mem_addr  = {r_addr_q[63:3], 3'b000};
  assign bus.mem_wdata = w_merged;
  assign bus.mem_rd    = w_mem_rd;
  assign bus.mem_wr    = w_mem_wr;
  assign bus.done      = w_mem_wr;
  assign bus.busy      = w_busy;
  assign bus.misalign  = w_misalign;

endmodule
